uart_word_assembler: RTL and testbench
======================================

# uart_word_assembler

Packs the byte stream produced by the UART receive stage into 32-bit little-endian words and buffers them in a small synchronous FIFO for the core's program/data loader. It sits directly downstream of the UART receiver, consuming its one-cycle byte strobe and framing-error flag, and presents a valid/ready word interface to the loader. It discards partial words on framing errors. Overflow and framing errors are reported through sticky flags.

## Interface
- `DEPTH`, 16, FIFO depth in words; power of two, ≥2.
- `clk`  in  1  system clock; everything on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a completed byte.
- `rx_data`  in  8  received byte; bit 0 is the first bit on the line.
- `rx_ferr`  in  1  qualifies `rx_valid`: stop bit was low, byte is bad.
- `flush`  in  1  synchronous discard of the partial word and all FIFO contents.
- `clr_err`  in  1  clears `overflow` and `ferr_seen`.
- `word_valid`  out  1  FIFO non-empty; `word_data` is valid.
- `word_data`  out  32  head-of-FIFO word (show-ahead).
- `word_ready`  in  1  loader accepts the head word when `word_valid` is high.
- `level`  out  $clog2(DEPTH)+1  words currently stored, 0..DEPTH.
- `overflow`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `ferr_seen`  out  1  sticky: a framing error occurred.

## Operation
- **Assembler state**
  - 2-bit byte counter `cnt` (0..3).
  - 24-bit holding register for bytes 0..2.
- **Good byte** (`rx_valid & ~rx_ferr`)
  - Byte lands in lane `cnt`: byte0 → [7:0], byte3 → [31:24].
  - If `cnt`<3: `cnt++`.
  - If `cnt`==3: push {`rx_data`, hold[23:0]} to the FIFO and set `cnt`←0.
- **Bad byte** (`rx_valid & rx_ferr`)
  - Byte is dropped.
  - `cnt`←0; the partial word is discarded.
  - `ferr_seen`←1.
- **Push**
  - Accepted if not full, or if full and a pop occurs in the same cycle (`level` unchanged).
  - Otherwise the word is dropped, `overflow`←1, and the FIFO is untouched.
  - The assembler still returns to `cnt`=0.
- **Pop**
  - Occurs when `word_valid & word_ready`.
  - `word_ready` while empty has no effect.
- **Push and pop in the same cycle while empty:** push only; the word is not bypassed.
- **Pointers**
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits and wrap naturally.
  - `level` = `wr_ptr` − `rd_ptr` (modulo).
  - Full when `level`==DEPTH.
- **`word_data`** is forced to 0 when empty.
- **`flush`**
  - Pointers←0, `cnt`←0.
  - An `rx_valid` or pop in the same cycle is ignored.
  - Sticky flags are unaffected.
- **`clr_err`**
  - Clears both sticky flags.
  - If a new error event occurs in the same cycle, set wins.
- **Reset priority:** `rst` > `flush` > normal operation.

## Timing
- **Reset values:** `word_valid`=0, `word_data`=0, `level`=0, `overflow`=0, `ferr_seen`=0; internally `cnt`=0 and pointers 0.
- **Fill latency:** the 4th good `rx_valid` in cycle N gives `word_valid`=1 and `level`+1 in cycle N+1.
- **Drain latency:** a pop in cycle N shows the next head word, or `word_valid`=0, in N+1.
- **Input rate:** `rx_valid` is accepted on any cycle, including back-to-back cycles, with no backpressure toward the receiver.
- **Reset mid-word:** the partial word is lost and there is no output activity.

## Structure
- **Package `uart_pkg`:**
  - `BYTE_W`=8, `WORD_W`=32, `BYTES_PER_WORD`=4.
  - typedef `byte_t` (logic [7:0]).
  - typedef `word_t` (logic [31:0]).
- **Sub-module `word_fifo`** (synchronous show-ahead FIFO).
  - Parameters: `DEPTH`, `W`.
  - Ports: `clk`, `rst`, `flush`, `push`, `push_data`, `pop`, `full`, `empty`, `level`, `head`.
  - Top level holds the assembler and the sticky flags.

## Test plan
- **Basic assembly:** reset, then bytes 0x78, 0x56, 0x34, 0x12 (good) → one cycle after the 4th strobe `word_valid`=1, `word_data`=0x12345678, `level`=1; pop → `level`=0, `word_data`=0.
- **Framing error:** bytes 0xAA, 0xBB, then 0xCC with `rx_ferr`=1, then 0x01, 0x02, 0x03, 0x04 → `ferr_seen`=1, exactly one word 0x04030201 is output, and 0xAA/0xBB never appear.
- **Overflow (DEPTH=16):** push 17 words, `word_ready`=0 → `level`=16, `overflow`=1; pops return words 1..16 in order; word 17 is absent.
- **Full push+pop:** at `level`=16 the 4th byte arrives in the same cycle as a pop → `level` stays 16, `overflow`=0, and the new word is at the tail.
- **Flush and clear:** 2 words stored plus 2 bytes pending, assert `flush` → `level`=0 and `word_valid`=0. The next 4 bytes form a fresh word. `clr_err` together with an `rx_ferr` strobe → `ferr_seen` stays 1.
- **Back-to-back and wrap:** `rx_valid` every cycle for 160 bytes with `word_ready`=1 → 40 words in order with no flags set, pointers wrap at least twice, and `level` is never above 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared widths and types for the UART receive-to-loader word path.
package uart_pkg;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/word_fifo.sv
// Synchronous show-ahead FIFO; head/level update the cycle after push/pop.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module word_fifo #(
  parameter int  DEPTH = 16,
  parameter int  W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] level,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/uart_word_assembler.sv
// Packs UART bytes little-endian into 32-bit words queued for the loader; word visible 1 cycle after 4th byte.
// No backpressure to the receiver: a word completing into a full FIFO is dropped and flagged.
module uart_word_assembler
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ferr,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic                     word_valid,
  output logic [31:0]              word_data,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     ferr_seen
);
  logic [1:0]                                cnt;
  logic [(BYTES_PER_WORD-1)*BYTE_W-1:0]      hold;
  logic                                      good;
  logic                                      bad;
  logic                                      last;
  logic                                      push_word;
  logic                                      pop;
  logic                                      fifo_full;
  logic                                      fifo_empty;
  logic                                      ovf_evt;
  word_t                                     push_data;
  word_t                                     head;

  // Flush swallows any byte strobe arriving in the same cycle.
  assign good      = rx_valid & ~rx_ferr & ~flush;
  assign bad       = rx_valid &  rx_ferr & ~flush;
  assign last      = (cnt == 2'(BYTES_PER_WORD - 1));
  assign push_word = good & last;
  assign push_data = {rx_data, hold};
  assign pop       = word_valid & word_ready;
  assign ovf_evt   = push_word & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      hold      <= '0;
      overflow  <= 1'b0;
      ferr_seen <= 1'b0;
    end else begin
      if (flush || bad) begin
        cnt <= '0;
      end else if (good) begin
        cnt <= last ? 2'd0 : cnt + 2'd1;
        case (cnt)
          2'd0:    hold[7:0]   <= rx_data;
          2'd1:    hold[15:8]  <= rx_data;
          2'd2:    hold[23:16] <= rx_data;
          default: ;
        endcase
      end
      // A new error event in the same cycle as clr_err wins.
      overflow  <= (overflow  & ~clr_err) | ovf_evt;
      ferr_seen <= (ferr_seen & ~clr_err) | bad;
    end
  end

  word_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push_word),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level),
    .head      (head)
  );

  assign word_valid = ~fifo_empty;
  assign word_data  = head;
endmodule

// File: tb/tb_uart_word_assembler.sv
// Randomized and directed bench for uart_word_assembler against a queue-based reference model.
module tb_uart_word_assembler;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ferr = 1'b0;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready = 1'b0;
  logic [4:0]  level;
  logic        overflow;
  logic        ferr_seen;

  uart_word_assembler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ferr    (rx_ferr),
    .flush      (flush),
    .clr_err    (clr_err),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .level      (level),
    .overflow   (overflow),
    .ferr_seen  (ferr_seen)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored words, pending bytes, sticky flags, and a log of popped words.
  logic [31:0] mq[$];
  logic [7:0]  part[$];
  logic [31:0] out_log[$];
  bit          m_ovf = 0;
  bit          m_ferr = 0;
  bit          popped, have_w, ev_o, ev_f;
  logic [31:0] new_w;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); part.delete(); m_ovf = 0; m_ferr = 0;
    end else if (flush) begin
      mq.delete(); part.delete();
      if (clr_err) begin m_ovf = 0; m_ferr = 0; end
    end else begin
      popped = word_ready && (mq.size() > 0);
      have_w = 0; ev_o = 0; ev_f = 0; new_w = '0;
      if (rx_valid) begin
        if (rx_ferr) begin
          part.delete(); ev_f = 1;
        end else begin
          part.push_back(rx_data);
          if (part.size() == 4) begin
            new_w = {part[3], part[2], part[1], part[0]};
            part.delete();
            if (mq.size() < DEPTH || popped) have_w = 1;
            else ev_o = 1;
          end
        end
      end
      if (popped) out_log.push_back(mq.pop_front());
      if (have_w) mq.push_back(new_w);
      if (clr_err) begin m_ovf = 0; m_ferr = 0; end
      if (ev_o) m_ovf = 1;
      if (ev_f) m_ferr = 1;
    end
  end

  bit cmp_en = 0;
  bit track_max = 0;
  int max_lvl = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("word_valid", 32'(word_valid), 32'(mq.size() > 0));
      check("word_data",  word_data, (mq.size() > 0) ? mq[0] : 32'h0);
      check("level",      32'(level), 32'(mq.size()));
      check("overflow",   32'(overflow), 32'(m_ovf));
      check("ferr_seen",  32'(ferr_seen), 32'(m_ferr));
      if (track_max && int'(level) > max_lvl) max_lvl = int'(level);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic f);
    rx_valid = 1'b1; rx_data = b; rx_ferr = f;
    tick();
    rx_valid = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], 1'b0);
  endtask

  task automatic pop_n(input int n);
    word_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    word_ready = 1'b0;
  endtask

  function automatic logic [31:0] wd(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {k, 8'hC3, 8'h5A, ~k};
  endfunction

  logic [7:0] sent[160];
  logic [31:0] w17;

  initial begin
    tick(); tick();
    cmp_en = 1;
    rst = 1'b0;
    check("reset word_valid", 32'(word_valid), 32'h0);
    check("reset word_data",  word_data, 32'h0);
    check("reset level",      32'(level), 32'h0);
    check("reset overflow",   32'(overflow), 32'h0);
    check("reset ferr_seen",  32'(ferr_seen), 32'h0);

    // Basic assembly
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0);
    check("pre-4th word_valid", 32'(word_valid), 32'h0);
    send(8'h12, 0);
    check("basic word_valid", 32'(word_valid), 32'h1);
    check("basic word_data",  word_data, 32'h12345678);
    check("basic level",      32'(level), 32'h1);
    out_log.delete();
    pop_n(1);
    check("basic drained level", 32'(level), 32'h0);
    check("basic drained data",  word_data, 32'h0);
    check("basic popped word",   (out_log.size() == 1) ? out_log[0] : 32'hDEAD_BEEF, 32'h12345678);

    // Framing error discards the partial word
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    check("ferr sticky", 32'(ferr_seen), 32'h1);
    check("ferr level",  32'(level), 32'h1);
    check("ferr word",   word_data, 32'h04030201);
    out_log.delete();
    pop_n(3);
    check("ferr one word out", 32'(out_log.size()), 32'h1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ferr cleared", 32'(ferr_seen), 32'h0);

    // Overflow
    for (int i = 1; i <= 17; i++) send_word(wd(i));
    check("ovf level", 32'(level), 32'd16);
    check("ovf flag",  32'(overflow), 32'h1);
    out_log.delete();
    pop_n(18);
    check("ovf drained count", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      check("ovf order", out_log[i], wd(i + 1));
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // Push into full FIFO with simultaneous pop
    for (int i = 1; i <= 16; i++) send_word(wd(i));
    w17 = 32'hFACE_0517;
    for (int i = 0; i < 3; i++) send(w17[8*i +: 8], 0);
    out_log.delete();
    rx_valid = 1'b1; rx_data = w17[31:24]; word_ready = 1'b1;
    tick();
    rx_valid = 1'b0; word_ready = 1'b0;
    check("fullpp level",    32'(level), 32'd16);
    check("fullpp overflow", 32'(overflow), 32'h0);
    pop_n(16);
    check("fullpp count", 32'(out_log.size()), 32'd17);
    if (out_log.size() == 17) begin
      check("fullpp head", out_log[0], wd(1));
      check("fullpp tail", out_log[16], w17);
    end

    // Flush and clear
    send_word(32'h1111_1111); send_word(32'h2222_2222);
    send(8'hE1, 0); send(8'hE2, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush level", 32'(level), 32'h0);
    check("flush valid", 32'(word_valid), 32'h0);
    send_word(32'hA5B6C7D8);
    check("post-flush word", word_data, 32'hA5B6C7D8);
    pop_n(1);
    clr_err = 1'b1; rx_valid = 1'b1; rx_ferr = 1'b1; rx_data = 8'h55;
    tick();
    clr_err = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0;
    check("clr vs ferr set wins", 32'(ferr_seen), 32'h1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // Reset mid-word loses the partial bytes
    send(8'h99, 0); send(8'h98, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midreset level", 32'(level), 32'h0);
    send_word(32'h0BAD_F00D);
    check("midreset fresh word", word_data, 32'h0BAD_F00D);
    pop_n(1);

    // Back-to-back bytes with a ready loader
    out_log.delete();
    max_lvl = 0; track_max = 1;
    word_ready = 1'b1;
    for (int k = 0; k < 160; k++) begin
      sent[k] = 8'($urandom);
      rx_valid = 1'b1; rx_data = sent[k]; rx_ferr = 1'b0;
      tick();
    end
    rx_valid = 1'b0;
    tick(); tick();
    word_ready = 1'b0; track_max = 0;
    check("b2b word count", 32'(out_log.size()), 32'd40);
    for (int i = 0; i < 40 && i < out_log.size(); i++)
      check("b2b word", out_log[i], {sent[4*i+3], sent[4*i+2], sent[4*i+1], sent[4*i]});
    check("b2b max level", 32'(max_lvl <= 1), 32'h1);
    check("b2b overflow", 32'(overflow), 32'h0);
    check("b2b ferr", 32'(ferr_seen), 32'h0);

    // Random traffic, per-cycle model comparison
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 599) == 0);
      flush      = ($urandom_range(0, 99) == 0);
      clr_err    = ($urandom_range(0, 39) == 0);
      rx_valid   = $urandom_range(0, 1) == 1;
      rx_ferr    = ($urandom_range(0, 24) == 0);
      rx_data    = 8'($urandom);
      word_ready = ((c / 500) % 2 == 0) ? ($urandom_range(0, 7) == 0)
                                        : ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; clr_err = 1'b0; rx_valid = 1'b0; word_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
